// File: rtl/serial_load_ctrl_pkg.sv
// Shared definitions for the serial load controller: state encoding, widths
// and the index-to-register-bit mapping.
package serial_load_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 16;

  // Index i drives register bit (DATA_W-1-i), so the MSB goes out first.
  function automatic logic [SEL_W-1:0] bit_pos(input logic [SEL_W-1:0] idx);
    return 4'd15 - idx;
  endfunction

endpackage

// File: rtl/serial_load_ctrl_cnt.sv
// Bit index counter for the serial load sequence: synchronous clear,
// count enable and terminal-count flag at NBITS-1.
import serial_load_ctrl_pkg::*;

module serial_load_cnt #(
  parameter int NBITS = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             tc_o
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NBITS - 1);

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)     idx_d = '0;
    else if (en_i) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign idx_o = idx_q;
  assign tc_o  = (idx_q == LAST);

endmodule

// File: rtl/serial_load_ctrl.sv
// Serial load sequencer: shifts a captured 16-bit word into a bit-addressed
// register, MSB first. Optional PARITY output under SERIAL_LOAD_PARITY_EN.
import serial_load_ctrl_pkg::*;

module serial_load_ctrl #(
  parameter int NBITS = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] DATA,
  input  logic              HOLD,
  input  logic              ABORT,
  output logic [SEL_W-1:0]  SEL,
  output logic              ENA,
  output logic              D,
  output logic              BUSY,
`ifdef SERIAL_LOAD_PARITY_EN
  output logic              PARITY,
`endif
  output logic              DONE
);

  state_e            state_q;
  logic [DATA_W-1:0] shadow_q;
  logic [SEL_W-1:0]  sel_q;
  logic              ena_q;
  logic              d_q;
  logic              busy_q;
  logic              done_q;

  logic              cnt_clr;
  logic              cnt_en;
  logic [SEL_W-1:0]  cnt_idx;
  logic              cnt_tc;
  logic [SEL_W-1:0]  idx_nxt;

  // The index register always matches the bit currently presented on SEL/D.
  always_comb begin
    cnt_clr = (state_q == IDLE) && START;
    cnt_en  = (state_q == LOAD) && !ABORT && !HOLD && !cnt_tc;
    idx_nxt = cnt_idx + 1'b1;
  end

  serial_load_cnt #(
    .NBITS (NBITS)
  ) u_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .idx_o (cnt_idx),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sel_q    <= '0;
      ena_q    <= 1'b0;
      d_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q  <= LOAD;
            shadow_q <= DATA;
            sel_q    <= '0;
            ena_q    <= 1'b1;
            d_q      <= DATA[DATA_W-1];
            busy_q   <= 1'b1;
          end
        end
        LOAD: begin
          if (ABORT) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ena_q   <= 1'b0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else if (HOLD) begin
            ena_q <= 1'b0;
          end else if (cnt_tc) begin
            state_q <= FIN;
            sel_q   <= '0;
            ena_q   <= 1'b0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            sel_q <= idx_nxt;
            ena_q <= 1'b1;
            d_q   <= shadow_q[bit_pos(idx_nxt)];
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          ena_q   <= 1'b0;
          d_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_LOAD_PARITY_EN
  logic parity_q;

  // Accumulates every bit actually written (ENA high at the edge).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                parity_q <= 1'b0;
    else if ((state_q == IDLE) && START)    parity_q <= 1'b0;
    else if ((state_q == LOAD) && ena_q)    parity_q <= parity_q ^ d_q;
  end

  assign PARITY = parity_q;
`endif

  assign SEL  = sel_q;
  assign ENA  = ena_q;
  assign D    = d_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
